tx_gate_ctrl_list: RTL
======================

# tx_gate_ctrl_list

Per-port 802.1Qbv gate control list (GCL) executor in the TX MAC scheduling pipeline. It stores a programmable list of (gate-state, interval) entries and steps through it cyclically. It drives the per-priority gate-open vector that the QoS scheduler consumes as its gate control list state. It is the producer side of the gate-state interface, so the QoS scheduler only ever sees registered, glitch-free gate vectors.

## Interface
- PORT_FIFO_PRI_NUM, 8, number of priority queues / gate bits
- GCL_DEPTH, 16, number of GCL entries (power of two)
- INTV_W, 24, interval width in clock cycles (4 ns at 250 MHz)

- i_clk  in  1  250 MHz clock
- i_rst  in  1  asynchronous, active-high reset
- i_gate_en  in  1  1 = execute GCL, 0 = idle on admin state
- i_admin_gate_state  in  PORT_FIFO_PRI_NUM  gate vector driven while idle
- i_gcl_len  in  $clog2(GCL_DEPTH)+1  number of valid entries, 0..GCL_DEPTH
- i_gcl_wr_en  in  1  table write strobe
- i_gcl_wr_addr  in  $clog2(GCL_DEPTH)  entry index
- i_gcl_wr_state  in  PORT_FIFO_PRI_NUM  gate vector of entry
- i_gcl_wr_intv  in  INTV_W  entry duration in cycles
- i_guard_band  in  16  guard-band length in cycles (only with TX_GCL_GUARD_BAND_EN)
- o_ControlList_state  out  PORT_FIFO_PRI_NUM  registered gate vector to QoS scheduler
- o_gcl_idx  out  $clog2(GCL_DEPTH)  index of entry currently driven
- o_cycle_start  out  1  one-cycle pulse when entry 0 becomes active
- o_gcl_wr_err  out  1  one-cycle pulse when a write is rejected

## Operation
- Table: GCL_DEPTH flop entries. Read is combinational. Table contents are not cleared by reset.
- FSM states: IDLE and RUN.
- IDLE → RUN when i_gate_en=1 and i_gcl_len≠0.
- RUN → IDLE when i_gate_en=0.
- i_gcl_len=0 with i_gate_en=1: the block stays in IDLE.
- Writes are accepted only in IDLE with i_gate_en=0.
  - A write in RUN, or in the cycle where i_gate_en=1, is dropped.
  - A dropped write pulses o_gcl_wr_err on the next cycle.
- IDLE outputs:
  - o_ControlList_state = i_admin_gate_state, registered.
  - o_gcl_idx = 0.
  - No o_cycle_start.
- RUN sequencing:
  - Remaining-cycle counter rem is loaded with max(intv,1) when an entry becomes active, then decrements each cycle.
  - When rem=1, idx advances. idx = i_gcl_len−1 wraps to 0.
  - Entry k is therefore driven for exactly max(intv_k,1) cycles. An interval of 0 is treated as 1.
  - o_cycle_start pulses on every cycle in which entry 0 becomes active, including the first.
- i_gcl_len is sampled only on the IDLE→RUN transition. Changes while in RUN are ignored.
- Reset mid-operation: immediate return to IDLE with reset outputs. The table is kept.

## Timing
- Reset values:
  - o_ControlList_state = all ones (all gates open).
  - o_gcl_idx = 0, o_cycle_start = 0, o_gcl_wr_err = 0.
  - FSM = IDLE.
- Enable latency: i_gate_en first sampled high at edge C → at C+1, o_ControlList_state = state[0], o_gcl_idx = 0, o_cycle_start = 1.
- Disable latency: i_gate_en sampled low at edge C → at C+1, o_ControlList_state = i_admin_gate_state and o_gcl_idx = 0.
- Entry transitions are bubble-free: the next entry's state appears on the cycle immediately after the last cycle of the current entry.
- Write latency: a write accepted at edge C is visible to a RUN that starts at C+1.

## Configuration
- Macro: TX_GCL_GUARD_BAND_EN.
- Defined:
  - i_guard_band exists.
  - While rem ≤ i_guard_band, gates that are open in the current entry but closed in the next entry (entry 0 after the last) are forced closed. Masked vector = state_k & state_next.
  - Gates that stay open, or that newly open in the next entry, are unaffected.
  - i_guard_band = 0 means no masking.
  - If i_guard_band ≥ the interval, the whole entry is masked.
- Undefined:
  - i_guard_band port is absent.
  - Entry states are output unmasked.

## Test plan
- Reset then idle: i_admin_gate_state=8'hA5, i_gate_en=0 → output 8'hFF during reset, 8'hA5 one cycle after reset release, o_cycle_start never set.
- Basic cycle: len=3, entries (8'h01,4),(8'h02,2),(8'h80,0); enable → output 01×4, 02×2, 80×1 cycles, repeating. o_cycle_start pulses every 7 cycles. idx sequence 0,1,2.
- Write rejection: in RUN, write addr 1 → o_gcl_wr_err pulse one cycle later and the sequence is unchanged. After disable, the same write is accepted and the new value is seen after re-enable.
- Disable and reset mid-entry: drop i_gate_en in the 2nd cycle of entry 0 → admin state on the next cycle. Re-enable → restart at entry 0 with a fresh full interval. Assert i_rst mid-RUN → output 8'hFF immediately, and table contents persist on re-enable.
- Boundary: len=0 with enable → stays on admin state. len=GCL_DEPTH with all intervals 1 → idx 0..15 wraps each cycle and o_cycle_start fires every 16 cycles.
- Guard band (macro defined): entries (8'h03,10),(8'h01,10), i_guard_band=3 → bit1 is cleared in the last 3 cycles of entry 0 (output 8'h01). Entry 1 is unmasked, because its next entry (entry 0) reopens bit1. With the macro undefined → output 8'h03 for the full 10 cycles.

Source files
------------

// File: rtl/tx_gate_ctrl_list_if.sv
// Gate-state interface between the TX gate control list executor and its environment.
// Carries the GCL table write port, the enable/admin controls and the registered
// gate vector consumed by the QoS scheduler.
//   master : drives i_* signals (configuration / control side)
//   slave  : the executor itself; drives o_* signals
// Optional macro TX_GCL_GUARD_BAND_EN adds i_guard_band.
interface tx_gate_ctrl_list_if #(
  parameter int unsigned PORT_FIFO_PRI_NUM = 8,
  parameter int unsigned GCL_DEPTH         = 16,
  parameter int unsigned INTV_W            = 24
) ();
  localparam int unsigned IdxW = $clog2(GCL_DEPTH);
  localparam int unsigned LenW = IdxW + 1;

  logic                         i_gate_en;
  logic [PORT_FIFO_PRI_NUM-1:0] i_admin_gate_state;
  logic [LenW-1:0]              i_gcl_len;
  logic                         i_gcl_wr_en;
  logic [IdxW-1:0]              i_gcl_wr_addr;
  logic [PORT_FIFO_PRI_NUM-1:0] i_gcl_wr_state;
  logic [INTV_W-1:0]            i_gcl_wr_intv;
`ifdef TX_GCL_GUARD_BAND_EN
  logic [15:0]                  i_guard_band;
`endif
  logic [PORT_FIFO_PRI_NUM-1:0] o_ControlList_state;
  logic [IdxW-1:0]              o_gcl_idx;
  logic                         o_cycle_start;
  logic                         o_gcl_wr_err;

  modport master (
`ifdef TX_GCL_GUARD_BAND_EN
    output i_guard_band,
`endif
    output i_gate_en, i_admin_gate_state, i_gcl_len, i_gcl_wr_en, i_gcl_wr_addr,
    output i_gcl_wr_state, i_gcl_wr_intv,
    input  o_ControlList_state, o_gcl_idx, o_cycle_start, o_gcl_wr_err
  );

  modport slave (
`ifdef TX_GCL_GUARD_BAND_EN
    input  i_guard_band,
`endif
    input  i_gate_en, i_admin_gate_state, i_gcl_len, i_gcl_wr_en, i_gcl_wr_addr,
    input  i_gcl_wr_state, i_gcl_wr_intv,
    output o_ControlList_state, o_gcl_idx, o_cycle_start, o_gcl_wr_err
  );
endinterface

// File: rtl/tx_gate_ctrl_list.sv
// Per-port 802.1Qbv gate control list executor.
// Stores GCL_DEPTH (gate-state, interval) entries and steps through the first
// i_gcl_len of them cyclically while enabled; otherwise drives the admin gate vector.
// All outputs are registered so the QoS scheduler sees glitch-free gate vectors.
// Ports:
//   i_clk  : clock
//   i_rst  : asynchronous active-high reset (table contents are kept)
//   bus    : tx_gate_ctrl_list_if slave (controls, table write port, gate outputs)
// Optional macro TX_GCL_GUARD_BAND_EN: closes gates that the next entry closes during
// the last i_guard_band cycles of each entry.
module tx_gate_ctrl_list #(
  parameter int unsigned PORT_FIFO_PRI_NUM = 8,
  parameter int unsigned GCL_DEPTH         = 16,
  parameter int unsigned INTV_W            = 24
) (
  input logic                i_clk,
  input logic                i_rst,
  tx_gate_ctrl_list_if.slave bus
);
  localparam int unsigned IdxW = $clog2(GCL_DEPTH);
  localparam int unsigned LenW = IdxW + 1;

  typedef logic [PORT_FIFO_PRI_NUM-1:0] gate_t;
  typedef enum logic [0:0] {StIdle, StRun} fsm_e;

  // Table: plain flops, no reset so configuration survives a port reset.
  gate_t             tbl_state_q [GCL_DEPTH];
  logic [INTV_W-1:0] tbl_intv_q  [GCL_DEPTH];

  fsm_e              fsm_q, fsm_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [INTV_W-1:0] rem_q, rem_d;
  gate_t             gate_q, gate_d;
  logic              cyc_start_q, cyc_start_d;
  logic              wr_err_q, wr_err_d;

  logic              wr_ok;
  logic [LenW-1:0]   len_in;
  logic [LenW-1:0]   len_eff;
  logic              load;
  logic [INTV_W-1:0] intv_raw;

  // Successor index within a list of length len (len >= 1).
  function automatic logic [IdxW-1:0] wrap_next(input logic [IdxW-1:0] idx,
                                                input logic [LenW-1:0] len);
    logic [LenW-1:0] inc;
    inc = {1'b0, idx} + LenW'(1);
    return (inc >= len) ? '0 : inc[IdxW-1:0];
  endfunction

  // Writes only while idle and not about to start, so the running list is never torn.
  assign wr_ok  = bus.i_gcl_wr_en && (fsm_q == StIdle) && !bus.i_gate_en;
  assign len_in = (bus.i_gcl_len > LenW'(GCL_DEPTH)) ? LenW'(GCL_DEPTH) : bus.i_gcl_len;

  always_ff @(posedge i_clk) begin
    if (wr_ok) begin
      tbl_state_q[bus.i_gcl_wr_addr] <= bus.i_gcl_wr_state;
      tbl_intv_q[bus.i_gcl_wr_addr]  <= bus.i_gcl_wr_intv;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    len_d       = len_q;
    len_eff     = len_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    cyc_start_d = 1'b0;
    load        = 1'b0;
    intv_raw    = '0;
    wr_err_d    = bus.i_gcl_wr_en && !wr_ok;

    unique case (fsm_q)
      StIdle: begin
        if (bus.i_gate_en && (len_in != '0)) begin
          fsm_d       = StRun;
          len_d       = len_in;
          len_eff     = len_in;
          idx_d       = '0;
          load        = 1'b1;
          cyc_start_d = 1'b1;
        end
      end
      StRun: begin
        if (!bus.i_gate_en) begin
          fsm_d = StIdle;
          idx_d = '0;
          rem_d = '0;
        end else if (rem_q == INTV_W'(1)) begin
          // Last cycle of current entry: next entry is driven without a bubble.
          idx_d       = wrap_next(idx_q, len_q);
          load        = 1'b1;
          cyc_start_d = (idx_d == '0);
        end else begin
          rem_d = rem_q - INTV_W'(1);
        end
      end
      default: begin
        fsm_d = StIdle;
        idx_d = '0;
      end
    endcase

    if (load) begin
      intv_raw = tbl_intv_q[idx_d];
      rem_d    = (intv_raw == '0) ? INTV_W'(1) : intv_raw;
    end

    // rem_d is the remaining count of the cycle gate_d will be shown in.
    gate_d = bus.i_admin_gate_state;
    if (fsm_d == StRun) begin
      gate_d = tbl_state_q[idx_d];
`ifdef TX_GCL_GUARD_BAND_EN
      if (32'(rem_d) <= 32'(bus.i_guard_band)) begin
        gate_d = gate_d & tbl_state_q[wrap_next(idx_d, len_eff)];
      end
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fsm_q       <= StIdle;
      len_q       <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      gate_q      <= '1;
      cyc_start_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      gate_q      <= gate_d;
      cyc_start_q <= cyc_start_d;
      wr_err_q    <= wr_err_d;
    end
  end

  assign bus.o_ControlList_state = gate_q;
  assign bus.o_gcl_idx           = idx_q;
  assign bus.o_cycle_start       = cyc_start_q;
  assign bus.o_gcl_wr_err        = wr_err_q;

endmodule
